// File: rtl/bcd7_pkg.sv
// ============================================================================
// Module : bcd7_pkg
// Brief  : Segment constants and sizing helper shared by the BCD 7-seg driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd7_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd7_decode.sv
// ============================================================================
// Module : bcd7_decode
// Brief  : Combinational BCD code to active-high segment decoder with blank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd7_decode
    import bcd7_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        if (!i_blank) begin
            case (i_code)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_7seg_mux_driver.sv
// ============================================================================
// Module : bcd_7seg_mux_driver
// Brief  : Time-multiplexed, double-buffered BCD seven-segment display driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_7seg_mux_driver
    import bcd7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int                    IDX_W      = idx_width(NUM_DIGITS);
    localparam int                    DIV_W      = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]      c_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Pin-level "off" patterns double as XOR masks for polarity inversion
    localparam logic [6:0]            c_SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  c_DP_OFF   = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF   = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_bcd, r_pend_bcd;
    logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
    logic                    r_pending;
    logic [6:0]              r_display;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_done;

    logic                    w_div_wrap;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_an_hot;
    logic [3:0]              w_code;
    logic                    w_dp_cur;
    logic                    w_blank_cur;
    logic [6:0]              w_seg;

    assign w_div_wrap  = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_div_wrap && (r_idx == c_IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // A load coinciding with frame end bypasses the pending buffer entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_bcd  <= '0;
            r_act_dp   <= '0;
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
        end else if (w_frame_end) begin
            r_pending <= 1'b0;
            if (load) begin
                r_act_bcd <= bcd_in;
                r_act_dp  <= dp_in;
            end else if (r_pending) begin
                r_act_bcd <= r_pend_bcd;
                r_act_dp  <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_bcd <= bcd_in;
            r_pend_dp  <= dp_in;
            r_pending  <= 1'b1;
        end
    end

    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_act_bcd[4*i +: 4] == 4'd0);
            w_lz_mask[i] = blank_lz && w_zero_above && (i != 0);
        end
    end

    always_comb begin
        w_code      = '0;
        w_dp_cur    = 1'b0;
        w_blank_cur = 1'b0;
        w_an_hot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code      = r_act_bcd[4*i +: 4];
                w_dp_cur    = r_act_dp[i];
                w_blank_cur = w_lz_mask[i];
                w_an_hot[i] = !w_lz_mask[i];
            end
        end
    end

    bcd7_decode u_decode (
        .i_code  (w_code),
        .i_blank (w_blank_cur),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display    <= c_SEG_OFF;
            r_dp         <= c_DP_OFF;
            r_anode      <= c_AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_display    <= w_seg ^ c_SEG_OFF;
            r_dp         <= (w_dp_cur && !w_blank_cur) ^ c_DP_OFF;
            r_anode      <= w_an_hot ^ c_AN_OFF;
            r_frame_done <= w_frame_end;
        end
    end

    assign display    = r_display;
    assign dp         = r_dp;
    assign anode      = r_anode;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_7seg_mux_driver.sv
// ============================================================================
// Module : tb_bcd_7seg_mux_driver
// Brief  : Self-checking bench for bcd_7seg_mux_driver against a cycle model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_7seg_mux_driver;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int FRAME = N * R;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] bcd_in   = '0;
    logic [3:0]  dp_in    = '0;
    logic [6:0]  display;
    logic        dp;
    logic [3:0]  anode;
    logic        pending;
    logic        frame_done;
    logic [13:0] w_obs;

    bcd_7seg_mux_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .display    (display),
        .dp         (dp),
        .anode      (anode),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign w_obs = {display, dp, anode, frame_done, pending};

    int checks = 0;
    int fails  = 0;

    // Model: n counts clock edges since reset release
    int          n;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pending;
    logic [13:0] e_vec;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic model_reset();
        n = 0; m_act = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pending = 1'b0;
    endtask

    // Predict the pins after the next edge, then advance to 1 time unit past it
    task automatic tick();
        int         idx;
        logic       fe, blank;
        logic [6:0] e_disp;
        logic       e_dp;
        logic [3:0] e_an;
        idx   = (n / R) % N;
        fe    = (n % FRAME) == FRAME - 1;
        blank = blank_lz && (idx != 0) && ((m_act >> (4 * idx)) == 16'd0);
        if (blank) begin
            e_disp = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            e_disp = ~seg_tab[m_act[4*idx +: 4]];
            e_dp   = ~m_dp[idx];
            e_an   = ~(4'b0001 << idx);
        end
        if (fe) begin
            if (load) begin
                m_act = bcd_in; m_dp = dp_in;
            end else if (m_pending) begin
                m_act = m_pend; m_dp = m_pdp;
            end
            m_pending = 1'b0;
        end else if (load) begin
            m_pend = bcd_in; m_pdp = dp_in; m_pending = 1'b1;
        end
        e_vec = {e_disp, e_dp, e_an, fe, m_pending};
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (anode !== 4'hF)    begin fails++; $display("FAIL reset_anode got %h exp f", anode); end
        checks++; if (display !== 7'h7F) begin fails++; $display("FAIL reset_display got %h exp 7f", display); end
        checks++; if (dp !== 1'b1)       begin fails++; $display("FAIL reset_dp got %b exp 1", dp); end
        checks++; if (pending !== 1'b0)  begin fails++; $display("FAIL reset_pending got %b exp 0", pending); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_frame();
        for (int k = 0; k < FRAME + 2; k++) begin
            tick();
            checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL first_frame n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        checks++; if (display !== 7'h40) begin fails++; $display("FAIL first_frame_zero got %h exp 40", display); end
    endtask

    task automatic test_load_mid_frame();
        while ((n % FRAME) != 5) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL mid_load_pre n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        load = 1'b1; bcd_in = 16'h1389; dp_in = 4'b0010;
        tick(); load = 1'b0;
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL mid_load_pending got %b exp 1", pending); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL mid_load n=%0d got %h exp %h", n, w_obs, e_vec); end
            if ((n % FRAME) == R + 1) begin
                checks++;
                if (display !== 7'h00 || dp !== 1'b0)
                    begin fails++; $display("FAIL mid_load_digit8 got %h/%b exp 00/0", display, dp); end
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            load = 1'b1; bcd_in = vals[v]; dp_in = 4'b1111;
            tick(); load = 1'b0;
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick(); checks++;
                if (w_obs !== e_vec) begin fails++; $display("FAIL blank_lz v=%0d n=%0d got %h exp %h", v, n, w_obs, e_vec); end
            end
        end
        checks++; if (anode !== 4'hF) begin fails++; $display("FAIL blank_lz_slot3 got %h exp f", anode); end
        blank_lz = 1'b0;
    endtask

    task automatic test_dash();
        load = 1'b1; bcd_in = 16'h00A5; dp_in = 4'b0000;
        tick(); load = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL dash n=%0d got %h exp %h", n, w_obs, e_vec); end
            if ((n % FRAME) == R + 2) begin
                checks++;
                if (display !== 7'h3F) begin fails++; $display("FAIL dash_slot1 got %h exp 3f", display); end
            end
        end
    endtask

    task automatic test_frame_end_load();
        while ((n % FRAME) != FRAME - 1) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL fe_load_pre n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        load = 1'b1; bcd_in = 16'h1111; dp_in = 4'b0000;
        tick(); load = 1'b0;
        checks++; if (pending !== 1'b0)    begin fails++; $display("FAIL fe_load_pending got %b exp 0", pending); end
        checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL fe_load_frame_done got %b exp 1", frame_done); end
        for (int k = 0; k < FRAME + 1; k++) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL fe_load n=%0d got %h exp %h", n, w_obs, e_vec); end
            if (k < FRAME && anode !== 4'hF) begin
                checks++;
                if (display !== 7'h79) begin fails++; $display("FAIL fe_load_one got %h exp 79", display); end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            load = ($urandom_range(0, 7) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bcd_in = bcd_in & 16'($urandom_range(0, 3) == 0 ? 16'h0000 : 16'h00FF);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL random n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        load = 1'b0; blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        while ((n % FRAME) != 2) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL rst_mid_pre n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        load = 1'b1; bcd_in = 16'h4321; dp_in = 4'b0101;
        tick(); load = 1'b0;
        while ((n % FRAME) != 9) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL rst_mid_run n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        checks++; if (pending !== 1'b1) begin fails++; $display("FAIL rst_mid_pending_before got %b exp 1", pending); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0})
            begin fails++; $display("FAIL rst_mid_async got %h exp %h", w_obs, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < FRAME + 4; k++) begin
            tick(); checks++;
            if (w_obs !== e_vec) begin fails++; $display("FAIL rst_mid_after n=%0d got %h exp %h", n, w_obs, e_vec); end
        end
        checks++; if (display !== 7'h40) begin fails++; $display("FAIL rst_mid_zero got %h exp 40", display); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_load_mid_frame();
        test_blank_lz();
        test_dash();
        test_frame_end_load();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
